vmem_ctrl_gen: RTL and testbench

- Parametrised vector-memory handshake controller.
- Bridges N_IDMA input-DMA and N_ODMA output-DMA req/ack channels to the vmem valid/ready ports through per-channel token buffers.
- Runs a per-kernel vector-store sequencer. It latches the kernel mode at kernel start, then joins or passes the kernel/ivs streams for exactly kernel_len beats.
- Sits between the DMA/kernel-arbiter fabric and the vmem core.

---
 rtl/vmem_ctrl_gen.sv | 153 +++++++++++++++
 tb/tb_vmem_ctrl_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_ctrl_gen.sv
// Vector-memory handshake controller: per-channel DMA token buffers plus a
// per-kernel vector-store sequencer that joins or passes the kernel/ivs streams.

module vmem_tok_buf #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push_req,
   output logic push_ack,
   output logic pop_valid,
   input  logic pop_ready
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          push, pop;

   always_comb begin
      // Ack is masked while reset is asserted so every output reads 0 in reset.
      push_ack  = reset_n & (cnt_q < CW'(DEPTH));
      pop_valid = (cnt_q != '0);
      push      = push_req & push_ack;
      pop       = pop_valid & pop_ready;
      cnt_d     = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

module vmem_ctrl_gen #(
   parameter int N_IDMA  = 4,
   parameter int N_ODMA  = 4,
   parameter int DEPTH   = 2,
   parameter int K_W     = 4,
   parameter int K_SPLIT = 8,
   parameter int LEN_W   = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_IDMA-1:0] t_idma_req,
   output logic [N_IDMA-1:0] t_idma_ack,
   output logic [N_IDMA-1:0] idma_valid,
   input  logic [N_IDMA-1:0] idma_ready,
   input  logic [N_ODMA-1:0] odma_valid,
   output logic [N_ODMA-1:0] odma_ready,
   output logic [N_ODMA-1:0] i_odma_req,
   input  logic [N_ODMA-1:0] i_odma_ack,
   input  logic              t_ka_req,
   output logic              t_ka_ack,
   input  logic              t_ivs_req,
   output logic              t_ivs_ack,
   output logic              tvs_valid,
   input  logic              tvs_ready,
   input  logic              ivs_valid,
   output logic              ivs_ready,
   output logic              i_ovs_req,
   input  logic              i_ovs_ack,
   input  logic [K_W-1:0]    k_ctrl,
   input  logic [LEN_W-1:0]  kernel_len,
   output logic              busy,
   output logic              kernel_done
);
   vmem_tok_buf #(.DEPTH(DEPTH)) u_idma [N_IDMA-1:0] (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_req  (t_idma_req),
      .push_ack  (t_idma_ack),
      .pop_valid (idma_valid),
      .pop_ready (idma_ready)
   );

   vmem_tok_buf #(.DEPTH(DEPTH)) u_odma [N_ODMA-1:0] (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_req  (odma_valid),
      .push_ack  (odma_ready),
      .pop_valid (i_odma_req),
      .pop_ready (i_odma_ack)
   );

   // The active state doubles as the mode latched at kernel start.
   typedef enum logic [1:0] {S_IDLE, S_JOIN, S_PASS} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             zdone_q, zdone_d;
   logic             beat, last;

   always_comb begin
      tvs_valid = 1'b0;
      t_ka_ack  = 1'b0;
      t_ivs_ack = 1'b0;
      ivs_ready = i_ovs_ack;
      i_ovs_req = ivs_valid;
      case (state_q)
         S_JOIN: begin
            tvs_valid = t_ka_req & t_ivs_req;
            t_ka_ack  = tvs_valid & tvs_ready;
            t_ivs_ack = t_ka_ack;
            ivs_ready = 1'b1;
         end
         S_PASS: begin
            tvs_valid = t_ka_req;
            t_ka_ack  = i_ovs_ack;
         end
         default: ;
      endcase

      beat        = t_ka_req & t_ka_ack;
      last        = beat & (rem_q == LEN_W'(1));
      kernel_done = last | zdone_q;
      busy        = busy_q;

      state_d = state_q;
      rem_d   = rem_q;
      zdone_d = 1'b0;
      if (state_q == S_IDLE) begin
         if (t_ka_req) begin
            if (kernel_len != '0) begin
               rem_d   = kernel_len;
               state_d = (int'(k_ctrl) < K_SPLIT) ? S_JOIN : S_PASS;
            end else begin
               zdone_d = 1'b1;
            end
         end
      end else if (beat) begin
         rem_d = rem_q - 1'b1;
         if (last) state_d = S_IDLE;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         zdone_q <= zdone_d;
      end
   end
endmodule

// File: tb/tb_vmem_ctrl_gen.sv
// Bench for vmem_ctrl_gen: token-buffer model checks plus a kernel scoreboard
// that records expected length/mode at kernel start and checks it on kernel_done.

module tb_vmem_ctrl_gen;
   localparam int N_IDMA = 4, N_ODMA = 4, DEPTH = 2, K_W = 4, K_SPLIT = 8, LEN_W = 16;

   logic              clk, reset_n;
   logic [N_IDMA-1:0] t_idma_req, t_idma_ack, idma_valid, idma_ready;
   logic [N_ODMA-1:0] odma_valid, odma_ready, i_odma_req, i_odma_ack;
   logic              t_ka_req, t_ka_ack, t_ivs_req, t_ivs_ack, tvs_valid, tvs_ready;
   logic              ivs_valid, ivs_ready, i_ovs_req, i_ovs_ack, busy, kernel_done;
   logic [K_W-1:0]    k_ctrl;
   logic [LEN_W-1:0]  kernel_len;

   vmem_ctrl_gen #(.N_IDMA(N_IDMA), .N_ODMA(N_ODMA), .DEPTH(DEPTH), .K_W(K_W),
                   .K_SPLIT(K_SPLIT), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .t_idma_req(t_idma_req), .t_idma_ack(t_idma_ack),
      .idma_valid(idma_valid), .idma_ready(idma_ready),
      .odma_valid(odma_valid), .odma_ready(odma_ready),
      .i_odma_req(i_odma_req), .i_odma_ack(i_odma_ack),
      .t_ka_req(t_ka_req), .t_ka_ack(t_ka_ack),
      .t_ivs_req(t_ivs_req), .t_ivs_ack(t_ivs_ack),
      .tvs_valid(tvs_valid), .tvs_ready(tvs_ready),
      .ivs_valid(ivs_valid), .ivs_ready(ivs_ready),
      .i_ovs_req(i_ovs_req), .i_ovs_ack(i_ovs_ack),
      .k_ctrl(k_ctrl), .kernel_len(kernel_len),
      .busy(busy), .kernel_done(kernel_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   typedef struct {int len; logic join_m;} kexp_t;
   kexp_t sbq[$];

   task automatic sb_push(input int len, input logic join_m);
      kexp_t e;
      e.len = len;
      e.join_m = join_m;
      sbq.push_back(e);
   endtask

   int icnt[N_IDMA], ocnt[N_ODMA], iacks[N_IDMA];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idma_cyc(input logic [N_IDMA-1:0] req, input logic [N_IDMA-1:0] rdy);
      t_idma_req = req;
      idma_ready = rdy;
      @(negedge clk);
      for (int i = 0; i < N_IDMA; i++) begin
         bit push, pop;
         chk($sformatf("idma_ack%0d", i), t_idma_ack[i], icnt[i] < DEPTH);
         chk($sformatf("idma_valid%0d", i), idma_valid[i], icnt[i] != 0);
         if (req[i] && t_idma_ack[i]) iacks[i]++;
         push = req[i] && (icnt[i] < DEPTH);
         pop  = rdy[i] && (icnt[i] != 0);
         icnt[i] = icnt[i] + int'(push) - int'(pop);
      end
      tick();
   endtask

   task automatic odma_cyc(input logic [N_ODMA-1:0] vld, input logic [N_ODMA-1:0] ack);
      odma_valid = vld;
      i_odma_ack = ack;
      @(negedge clk);
      for (int i = 0; i < N_ODMA; i++) begin
         bit push, pop;
         chk($sformatf("odma_ready%0d", i), odma_ready[i], ocnt[i] < DEPTH);
         chk($sformatf("odma_req%0d", i), i_odma_req[i], ocnt[i] != 0);
         push = vld[i] && (ocnt[i] < DEPTH);
         pop  = ack[i] && (ocnt[i] != 0);
         ocnt[i] = ocnt[i] + int'(push) - int'(pop);
      end
      tick();
   endtask

   // Kernel monitor: counts beats and ivs acks, checks against the scoreboard on done.
   int   mbeats;
   logic msaw;
   always @(negedge clk) begin
      if (!reset_n) begin
         mbeats = 0;
         msaw   = 1'b0;
      end else begin
         if (t_ka_req && t_ka_ack) mbeats++;
         if (t_ivs_ack) msaw = 1'b1;
         if (kernel_done) begin
            if (sbq.size() == 0) chk("sb_unexpected_done", 1, 0);
            else begin
               kexp_t e;
               e = sbq.pop_front();
               chk("sb_len", mbeats, e.len);
               chk("sb_mode_join", msaw, e.join_m);
            end
            mbeats = 0;
            msaw   = 1'b0;
         end
      end
   end

   task automatic run_kernel(input logic [K_W-1:0] k, input int len, input logic [31:0] ivs_pat,
                             input logic [31:0] ovs_pat, input bit chg);
      bit   jm, done;
      int   nb;
      jm = (int'(k) < K_SPLIT);
      nb = 0;
      done = 0;
      k_ctrl = k; kernel_len = LEN_W'(len); t_ka_req = 1; t_ivs_req = 0; i_ovs_ack = 0;
      tvs_ready = 1; ivs_valid = 0;
      sb_push(len, jm);
      @(negedge clk);
      chk("start_ka_ack", t_ka_ack, 0);
      chk("start_busy", busy, 0);
      tick();
      for (int c = 1; c < 40 && !done; c++) begin
         t_ivs_req = ivs_pat[c];
         i_ovs_ack = ovs_pat[c];
         ivs_valid = c[0];
         if (chg && c == 2) begin k_ctrl = 12; kernel_len = 1; end
         @(negedge clk);
         chk("run_busy", busy, 1);
         chk("run_ovs_req", i_ovs_req, c[0]);
         if (jm) begin
            chk("join_tvs_valid", tvs_valid, ivs_pat[c]);
            chk("join_ka_ack", t_ka_ack, ivs_pat[c]);
            chk("join_ivs_ack", t_ivs_ack, ivs_pat[c]);
            chk("join_ivs_ready", ivs_ready, 1);
         end else begin
            chk("pass_tvs_valid", tvs_valid, 1);
            chk("pass_ka_ack", t_ka_ack, ovs_pat[c]);
            chk("pass_ivs_ack", t_ivs_ack, 0);
            chk("pass_ivs_ready", ivs_ready, ovs_pat[c]);
         end
         if (t_ka_ack) nb++;
         if (kernel_done) begin
            done = 1;
            chk("done_on_last_beat", nb, len);
         end
         tick();
      end
      if (!done) chk("kernel_timeout", 0, 1);
      t_ka_req = 0; t_ivs_req = 0; i_ovs_ack = 0; ivs_valid = 0;
      @(negedge clk);
      chk("after_done_busy", busy, 0);
      chk("after_done_pulse", kernel_done, 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 0; t_idma_req = 0; idma_ready = 0; odma_valid = 0; i_odma_ack = 0;
      t_ka_req = 0; t_ivs_req = 0; tvs_ready = 0; ivs_valid = 0; i_ovs_ack = 0;
      k_ctrl = 0; kernel_len = 0;
      for (int i = 0; i < N_IDMA; i++) begin icnt[i] = 0; iacks[i] = 0; end
      for (int i = 0; i < N_ODMA; i++) ocnt[i] = 0;
      repeat (2) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", kernel_done, 0);
      chk("rst_idma_ack", t_idma_ack, 0);
      chk("rst_idma_valid", idma_valid, 0);
      chk("rst_odma_ready", odma_ready, 0);
      chk("rst_odma_req", i_odma_req, 0);
      chk("rst_tvs_valid", tvs_valid, 0);
      chk("rst_ka_ack", t_ka_ack, 0);
      i_ovs_ack = 1;
      #1;
      chk("rst_ivs_ready_follows", ivs_ready, 1);
      i_ovs_ack = 0;
      #1;
      chk("rst_ivs_ready_low", ivs_ready, 0);
      tick();
      reset_n = 1;
      tick();

      // Single token on channel 2, then drain.
      idma_cyc(4'b0100, 4'b0000);
      idma_cyc(4'b0000, 4'b0000);
      idma_cyc(4'b0000, 4'b0100);
      idma_cyc(4'b0000, 4'b0100);
      idma_cyc(4'b0000, 4'b0000);

      // Fill channel 0 to DEPTH, one pop, refill.
      iacks[0] = 0;
      repeat (4) idma_cyc(4'b0001, 4'b0000);
      chk("idma0_acks_full", iacks[0], 2);
      idma_cyc(4'b0001, 4'b0001);
      idma_cyc(4'b0001, 4'b0000);
      idma_cyc(4'b0001, 4'b0000);
      chk("idma0_acks_refill", iacks[0], 3);
      repeat (3) idma_cyc(4'b0000, 4'b0001);

      // Simultaneous push and pop at count 1 on channel 3.
      idma_cyc(4'b1000, 4'b0000);
      idma_cyc(4'b1000, 4'b1000);
      idma_cyc(4'b0000, 4'b1000);
      idma_cyc(4'b0000, 4'b0000);

      // Output-DMA buffers.
      repeat (3) odma_cyc(4'b0011, 4'b0000);
      odma_cyc(4'b0011, 4'b0001);
      repeat (3) odma_cyc(4'b0000, 4'b0011);
      odma_cyc(4'b0000, 4'b0000);

      // JOIN kernel with mode/length changed mid-kernel, then PASS kernels.
      run_kernel(3, 4, 32'hAAAA_AAAA, 32'h0, 1);
      run_kernel(k_ctrl, int'(kernel_len), 32'h0, 32'h2, 0);
      run_kernel(9, 3, 32'h0, 32'h64, 0);

      // Zero-length kernel.
      kernel_len = 0; t_ka_req = 1;
      sb_push(0, 1'b0);
      @(negedge clk);
      chk("zlen_ka_ack", t_ka_ack, 0);
      chk("zlen_ivs_ack", t_ivs_ack, 0);
      chk("zlen_done_early", kernel_done, 0);
      tick();
      t_ka_req = 0;
      @(negedge clk);
      chk("zlen_done", kernel_done, 1);
      chk("zlen_busy", busy, 0);
      tick();
      @(negedge clk);
      chk("zlen_done_clear", kernel_done, 0);
      tick();

      // Reset in the middle of a JOIN kernel with a buffered idma token.
      k_ctrl = 3; kernel_len = 4; t_ka_req = 1; t_ivs_req = 1; tvs_ready = 1;
      t_idma_req = 4'b0010; idma_ready = 0;
      sb_push(4, 1'b1);
      tick();
      t_idma_req = 0;
      tick();
      tick();
      @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_idma_valid1", idma_valid[1], 1);
      chk("mid_no_done", kernel_done, 0);
      #1;
      reset_n = 0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_idma_valid", idma_valid, 0);
      chk("arst_tvs_valid", tvs_valid, 0);
      chk("arst_ka_ack", t_ka_ack, 0);
      sbq.delete();
      t_ka_req = 0; t_ivs_req = 0;
      for (int i = 0; i < N_IDMA; i++) icnt[i] = 0;
      tick();
      reset_n = 1;
      tick();
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_idma_valid", idma_valid, 0);
      chk("post_rst_idma_ack", t_idma_ack, 4'hF);
      tick();

      chk("sb_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
